// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_HOLD = 2'd1,
    S_REL  = 2'd2,
    S_DONE = 2'd3
  } seq_state_t;

  localparam int unsigned RC_W = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request/status bundle between the reset sequencer and its consumers.
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int unsigned N_CH = 3
) ();

  logic                 sw_rst_req;
  logic [N_CH-1:0]      ack_in;
  logic [N_CH-1:0]      rstn_out;
  logic                 busy;
  logic                 done;
  logic [RC_W-1:0]      restart_cnt;

  modport master (
    output sw_rst_req,
    output ack_in,
    input  rstn_out,
    input  busy,
    input  done,
    input  restart_cnt
  );

  modport slave (
    input  sw_rst_req,
    input  ack_in,
    output rstn_out,
    output busy,
    output done,
    output restart_cnt
  );

endinterface

// File: rtl/reset_sequencer_sync_chain.sv
// Async-clear shift register that synchronises rst_level deassertion.
module rst_sync_chain #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  output logic sync_ok
);

  logic [DEPTH-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[DEPTH-2:0], 1'b1};
    end
  end

  assign sync_ok = chain[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged multi-channel active-low reset generator with software restart.
// Optional macro RESET_SEQ_ACK_EN gates each release on the previous channel's ack.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned N_CH        = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_ASSERT  = 4,
  parameter int unsigned STAGE_GAP   = 3
) (
  input  logic                   clk,
  input  logic                   rst_level,
  reset_sequencer_if.slave       bus
);

  localparam int unsigned CNT_W = $clog2(max_u(MIN_ASSERT, STAGE_GAP) + 1);
  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wait_q, wait_d;
  logic [N_CH-1:0]  rstn_q, rstn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [RC_W-1:0]  rcnt_q, rcnt_d;
  logic             rel;
  logic             sync_ok;

  rst_sync_chain #(.DEPTH(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst_level),
    .sync_ok (sync_ok)
  );

  always_ff @(posedge clk or posedge rst_level) begin
    if (rst_level) begin
      state_q <= S_SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      wait_q  <= 1'b0;
      rstn_q  <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      rstn_q  <= rstn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    rstn_d  = rstn_q;
    busy_d  = busy_q;
    done_d  = done_q;
    rcnt_d  = rcnt_q;
    rel     = 1'b0;

    if (bus.sw_rst_req && (state_q != S_SYNC)) begin
      state_d = S_HOLD;
      cnt_d   = CNT_W'(MIN_ASSERT - 1);
      idx_d   = '0;
      wait_d  = 1'b0;
      rstn_d  = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      if (rcnt_q != '1) rcnt_d = rcnt_q + 1'b1;
    end else begin
      unique case (state_q)
        // sync_ok is seen one edge after it rises, so the hold count is one shorter here
        S_SYNC: begin
          if (sync_ok) begin
            if (MIN_ASSERT == 1) begin
              rel = 1'b1;
            end else begin
              cnt_d   = CNT_W'(MIN_ASSERT - 2);
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) rel = 1'b1;
          else             cnt_d = cnt_q - 1'b1;
        end
        S_REL: begin
`ifdef RESET_SEQ_ACK_EN
          if (wait_q) begin
            if (bus.ack_in[idx_q - 1'b1]) begin
              wait_d = 1'b0;
              cnt_d  = CNT_W'(STAGE_GAP - 1);
            end
          end else
`endif
          if (cnt_q == '0) rel = 1'b1;
          else             cnt_d = cnt_q - 1'b1;
        end
        S_DONE: ;
        default: state_d = S_SYNC;
      endcase
    end

    if (rel) begin
      rstn_d[idx_q] = 1'b1;
      if (idx_q == IDX_W'(N_CH - 1)) begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        idx_d   = idx_q + 1'b1;
        cnt_d   = CNT_W'(STAGE_GAP - 1);
        state_d = S_REL;
`ifdef RESET_SEQ_ACK_EN
        wait_d  = 1'b1;
`endif
      end
    end
  end

`ifndef RESET_SEQ_ACK_EN
  logic unused_ack;
  assign unused_ack = ^bus.ack_in;
`endif

  assign bus.rstn_out    = rstn_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.restart_cnt = rcnt_q;

endmodule
